// File: rtl/vga_pkg.sv
// Shared VGA timing and screen geometry constants used by the timing
// generator and the downstream screen memory counter.
package vga_pkg;

  // 640x480@60 Hz timing, 100 MHz system clock divided down to 25 MHz.
  localparam int VGA_CLK_DIV   = 4;
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Counters are 10 bits wide, so neither total may exceed this.
  localparam int VGA_CNT_W     = 10;
  localparam int VGA_CNT_LIMIT = 1 << VGA_CNT_W;

  // Screen memory geometry: 320x240 pixels, one bit each, packed in 32-bit words.
  localparam int SCREEN_W             = 320;
  localparam int SCREEN_H             = 240;
  localparam int SCREEN_WORD_BITS     = 32;
  localparam int SCREEN_WORDS_PER_ROW = SCREEN_W / SCREEN_WORD_BITS;
  localparam int SCREEN_WORDS         = SCREEN_WORDS_PER_ROW * SCREEN_H;

  // True when val lies in the inclusive window [lo, hi].
  function automatic logic in_window(input logic [VGA_CNT_W-1:0] val,
                                     input logic [VGA_CNT_W-1:0] lo,
                                     input logic [VGA_CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock into pixel periods. pixel_clk is a registered
// one-cycle strobe in the last clk cycle of every CLK_DIV-cycle period;
// pixel_clk_next is its next-state value, so the parent can register
// outputs that must line up with the strobe.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixel_clk,
  output logic pixel_clk_next
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pixel_clk_q, pixel_clk_d;

  // Next divider value with explicit wrap, and the strobe it implies.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
    pixel_clk_d = (div_d == DIV_LAST);
  end

  // Divider and strobe registers; reset restarts the pixel period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q       <= '0;
      pixel_clk_q <= 1'b0;
    end else begin
      div_q       <= div_d;
      pixel_clk_q <= pixel_clk_d;
    end
  end

  assign pixel_clk      = pixel_clk_q;
  assign pixel_clk_next = pixel_clk_d;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel/line counters plus registered sync, active-window
// and end-of-frame decodes. All decodes are computed from the next-state
// counters so they move on exactly the same edge as h_count/v_count.
module vga_timing_generator
  import vga_pkg::*;
#(
  parameter int   CLK_DIV     = VGA_CLK_DIV,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_clk,
  output logic       vga_active,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_DISPLAY);
  localparam logic [9:0] V_ACT    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Reject geometries the 10-bit counters cannot hold, or a divider too short
  // to give a distinct strobe cycle.
  if (H_TOTAL > VGA_CNT_LIMIT || V_TOTAL > VGA_CNT_LIMIT) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("vga_timing_generator: CLK_DIV must be 2 or more");
  end

  logic       pixel_clk_next;
  logic [9:0] h_q, h_d, v_q, v_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       frame_end_q, frame_end_d;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk           (clk),
    .reset         (reset),
    .pixel_clk     (pixel_clk),
    .pixel_clk_next(pixel_clk_next)
  );

  // Advance the raster on each pixel strobe and decode outputs from the
  // counter values that will be live after this edge.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pixel_clk) begin
      if (h_q < H_LAST) begin
        h_d = h_q + 10'd1;
      end else begin
        h_d = '0;
        if (v_q < V_LAST) begin
          v_d = v_q + 10'd1;
        end else begin
          v_d = '0;
        end
      end
    end
    active_d    = (h_d < H_ACT) && (v_d < V_ACT);
    hsync_d     = in_window(h_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d     = in_window(v_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    frame_end_d = pixel_clk_next && (h_d == H_LAST) && (v_d == V_LAST);
  end

  // Raster state and registered decodes; reset aborts the frame at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q         <= '0;
      v_q         <= '0;
      active_q    <= 1'b1;
      hsync_q     <= ~SYNC_ACTIVE;
      vsync_q     <= ~SYNC_ACTIVE;
      frame_end_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      active_q    <= active_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign h_count    = h_q;
  assign v_count    = v_q;
  assign vga_active = active_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_end  = frame_end_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator. Two reduced-geometry
// instances run side by side and are compared every cycle against a raster
// model that derives every output from the number of clk edges since reset.
module tb_vga_timing_generator;

  typedef struct packed {
    logic       pclk;
    logic       active;
    logic       hs;
    logic       vs;
    logic       fe;
    logic [9:0] h;
    logic [9:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;

  logic       pclk_a, active_a, hs_a, vs_a, fe_a;
  logic [9:0] h_a, v_a;
  logic       pclk_b, active_b, hs_b, vs_b, fe_b;
  logic [9:0] h_b, v_b;

  int edges = 0;
  int checks = 0;
  int passes = 0;
  int strobes_a = 0, strobes_b = 0, act_a = 0, act_b = 0, fends_a = 0, fends_b = 0;
  bit counting = 1'b0;

  // Instance A: CLK_DIV 2, H 8/2/2/2, V 6/1/1/1, active-low sync (252 clk frame).
  vga_timing_generator #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_ACTIVE(1'b0)
  ) dut_a (
    .clk(clk), .reset(reset), .pixel_clk(pclk_a), .vga_active(active_a),
    .hsync(hs_a), .vsync(vs_a), .h_count(h_a), .v_count(v_a), .frame_end(fe_a)
  );

  // Instance B: CLK_DIV 3, H 10/3/4/3, V 5/2/2/2, active-high sync (660 clk frame).
  vga_timing_generator #(
    .CLK_DIV(3), .H_DISPLAY(10), .H_FRONT(3), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(5), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset), .pixel_clk(pclk_b), .vga_active(active_b),
    .hsync(hs_b), .vsync(vs_b), .h_count(h_b), .v_count(v_b), .frame_end(fe_b)
  );

  always #5 clk = ~clk;

  // Expected outputs t clk edges after reset release.
  function automatic exp_t model(input int t, input int cd,
                                 input int hd, input int hf, input int hsw, input int hb,
                                 input int vd, input int vf, input int vsw, input int vb,
                                 input logic sa);
    int   ht = hd + hf + hsw + hb;
    int   vt = vd + vf + vsw + vb;
    int   p  = t / cd;
    int   h  = p % ht;
    int   v  = (p / ht) % vt;
    exp_t e;
    e.pclk   = ((t % cd) == (cd - 1));
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.active = (h < hd) && (v < vd);
    e.hs     = (h >= hd + hf && h < hd + hf + hsw) ? sa : ~sa;
    e.vs     = (v >= vd + vf && v < vd + vf + vsw) ? sa : ~sa;
    e.fe     = e.pclk && (h == ht - 1) && (v == vt - 1);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d",
                  tag, edges, observed, expected);
  endtask

  task automatic checkAll();
    exp_t ea, eb;
    ea = model(edges, 2, 8, 2, 2, 2, 6, 1, 1, 1, 1'b0);
    eb = model(edges, 3, 10, 3, 4, 3, 5, 2, 2, 2, 1'b1);
    checkOutput("a_pixel_clk", 32'(pclk_a), 32'(ea.pclk));
    checkOutput("a_active", 32'(active_a), 32'(ea.active));
    checkOutput("a_hsync", 32'(hs_a), 32'(ea.hs));
    checkOutput("a_vsync", 32'(vs_a), 32'(ea.vs));
    checkOutput("a_frame_end", 32'(fe_a), 32'(ea.fe));
    checkOutput("a_h_count", 32'(h_a), 32'(ea.h));
    checkOutput("a_v_count", 32'(v_a), 32'(ea.v));
    checkOutput("b_pixel_clk", 32'(pclk_b), 32'(eb.pclk));
    checkOutput("b_active", 32'(active_b), 32'(eb.active));
    checkOutput("b_hsync", 32'(hs_b), 32'(eb.hs));
    checkOutput("b_vsync", 32'(vs_b), 32'(eb.vs));
    checkOutput("b_frame_end", 32'(fe_b), 32'(eb.fe));
    checkOutput("b_h_count", 32'(h_b), 32'(eb.h));
    checkOutput("b_v_count", 32'(v_b), 32'(eb.v));
    if (counting) begin
      if (edges < 252) begin
        strobes_a += int'(pclk_a);
        act_a     += int'(pclk_a && active_a);
        fends_a   += int'(fe_a);
      end
      if (edges < 660) begin
        strobes_b += int'(pclk_b);
        act_b     += int'(pclk_b && active_b);
        fends_b   += int'(fe_b);
      end
    end
  endtask

  // Run n clk cycles, checking both instances at every falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset) edges++;
      @(negedge clk);
      checkAll();
    end
  endtask

  // Drop reset between edges, check the outputs cleared without a clk edge,
  // hold it for a few cycles, then release on a falling edge.
  task automatic pulseReset(input int hold);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    edges = 0;
    checkAll();
    repeat (hold) begin
      @(negedge clk);
      checkAll();
    end
    @(negedge clk);
    reset = 1'b1;
    checkAll();
  endtask

  initial begin
    int n;
    // Reset state while held, then release.
    repeat (3) @(negedge clk);
    checkAll();
    reset = 1'b1;
    checkAll();

    // One full frame of each instance with strobe bookkeeping.
    counting = 1'b1;
    applyStimulus(660);
    counting = 1'b0;
    checkOutput("a_strobes_per_frame", 32'(strobes_a), 32'(252 / 2));
    checkOutput("a_active_strobes", 32'(act_a), 32'(8 * 6));
    checkOutput("a_frame_end_count", 32'(fends_a), 32'd1);
    checkOutput("b_strobes_per_frame", 32'(strobes_b), 32'(660 / 3));
    checkOutput("b_active_strobes", 32'(act_b), 32'(10 * 5));
    checkOutput("b_frame_end_count", 32'(fends_b), 32'd1);

    // Reset landing inside instance A's vsync line (line 7, a few pixels in).
    pulseReset(2);
    applyStimulus(7 * 14 * 2 + 5);
    checkOutput("a_in_vsync_before_reset", 32'(vs_a), 32'd0);
    pulseReset(1);
    checkOutput("a_vsync_released_by_reset", 32'(vs_a), 32'd1);

    // Random run lengths with asynchronous resets dropped at random points.
    for (int i = 0; i < 10; i++) begin
      n = int'($urandom_range(1, 700));
      applyStimulus(n);
      pulseReset(int'($urandom_range(0, 3)));
    end
    applyStimulus(700);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
